// File: rtl/pulse_measure_ctrl_if.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pulse_measure_ctrl_if                                         |
// | Purpose  : Handshake/result bundle between the pulse measurement         |
// |            sequencer and its requester / seven-segment display stage.   |
// | Signals  : start, psi, ack          - requester -> sequencer            |
// |            busy, valid, duration,                                        |
// |            bcd_2/1/0, overflow,                                          |
// |            timeout                  - sequencer -> requester            |
// | Modports : master (requester side), slave (sequencer side)               |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
interface pulse_measure_ctrl_if;
  logic       start;
  logic       psi;
  logic       ack;
  logic       busy;
  logic       valid;
  logic [7:0] duration;
  logic [3:0] bcd_2;
  logic [3:0] bcd_1;
  logic [3:0] bcd_0;
  logic       overflow;
  logic       timeout;

  modport master (
    output start, psi, ack,
    input  busy, valid, duration, bcd_2, bcd_1, bcd_0, overflow, timeout
  );

  modport slave (
    input  start, psi, ack,
    output busy, valid, duration, bcd_2, bcd_1, bcd_0, overflow, timeout
  );
endinterface
`default_nettype wire

// File: rtl/pulse_measure_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// +--------------------------------------------------------------------------+
// | Module   : pulse_measure_ctrl                                            |
// | Purpose  : Single-pulse duration measurement sequencer. Arms on start,   |
// |            waits for a clean rising edge of psi, counts the high cycles  |
// |            (saturating at 255), converts the count to three BCD digits   |
// |            with a serial shift-add-3 loop and holds the result under a  |
// |            valid/ack handshake.                                          |
// | Ports    : clk  - system clock, rising edge                              |
// |            rst  - asynchronous reset, active low                         |
// |            bus  - pulse_measure_ctrl_if.slave (start/psi/ack in,         |
// |                   busy/valid/duration/bcd_*/overflow/timeout out)        |
// | Params   : TIMEOUT_CYCLES - wait limit in ARMED+WAIT_HIGH (1..65535)     |
// | Options  : PULSE_TIMEOUT_EN - when defined, builds the wait counter that |
// |            aborts a measurement with timeout=1 after TIMEOUT_CYCLES.     |
// | Revision : 1.0  initial release                                          |
// +--------------------------------------------------------------------------+
module pulse_measure_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1000
) (
  input  logic                 clk,
  input  logic                 rst,
  pulse_measure_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_ARMED     = 3'd1,
    S_WAIT_HIGH = 3'd2,
    S_COUNT     = 3'd3,
    S_CONVERT   = 3'd4,
    S_DONE      = 3'd5
  } state_t;

  localparam logic [2:0] c_LAST_ITER = 3'd7;

  state_t      r_state;
  state_t      w_next;

  logic [7:0]  r_count;
  logic        r_ovf;
  logic [19:0] r_shift;    // {hundreds, tens, units, binary}
  logic [2:0]  r_iter;
  logic [19:0] w_dd;
  logic        w_wait_hit;

  logic        r_busy;
  logic        r_valid;
  logic [7:0]  r_duration;
  logic [11:0] r_bcd;
  logic        r_overflow;
  logic        r_timeout;

  // One double-dabble iteration: correct every BCD nibble that would exceed 9
  // after doubling, then shift the whole register left by one.
  function automatic logic [19:0] dd_step(input logic [19:0] v);
    logic [19:0] a;
    a = v;
    for (int k = 0; k < 3; k++) begin
      if (a[8 + 4*k +: 4] >= 4'd5) begin
        a[8 + 4*k +: 4] = a[8 + 4*k +: 4] + 4'd3;
      end
    end
    return {a[18:0], 1'b0};
  endfunction

  assign w_dd = dd_step(r_shift);

`ifdef PULSE_TIMEOUT_EN
  localparam logic [15:0] c_TIMEOUT = 16'(TIMEOUT_CYCLES);

  logic [15:0] r_wait;

  // Counts edges spent waiting for the pulse; frozen once counting starts.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_wait <= 16'd0;
    end else if (r_state == S_IDLE) begin
      r_wait <= 16'd0;
    end else if ((r_state == S_ARMED) || (r_state == S_WAIT_HIGH)) begin
      r_wait <= r_wait + 16'd1;
    end
  end

  // Fires on the edge at which the wait count reaches the limit.
  assign w_wait_hit = ((r_state == S_ARMED) || (r_state == S_WAIT_HIGH)) &&
                      ((r_wait + 16'd1) == c_TIMEOUT);
`else
  logic w_unused_cfg;
  assign w_unused_cfg = (TIMEOUT_CYCLES == 0);
  assign w_wait_hit   = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE: begin
        if (bus.start) w_next = S_ARMED;
      end
      S_ARMED: begin
        // A pulse already high at start must end before we can arm.
        if (w_wait_hit)    w_next = S_DONE;
        else if (!bus.psi) w_next = S_WAIT_HIGH;
      end
      S_WAIT_HIGH: begin
        if (w_wait_hit)   w_next = S_DONE;
        else if (bus.psi) w_next = S_COUNT;
      end
      S_COUNT: begin
        if (!bus.psi) w_next = S_CONVERT;
      end
      S_CONVERT: begin
        if (r_iter == c_LAST_ITER) w_next = S_DONE;
      end
      S_DONE: begin
        if (bus.ack) w_next = S_IDLE;
      end
      default: w_next = S_IDLE;
    endcase
  end

  // State, datapath and registered outputs
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state    <= S_IDLE;
      r_count    <= 8'd0;
      r_ovf      <= 1'b0;
      r_shift    <= 20'd0;
      r_iter     <= 3'd0;
      r_busy     <= 1'b0;
      r_valid    <= 1'b0;
      r_duration <= 8'd0;
      r_bcd      <= 12'd0;
      r_overflow <= 1'b0;
      r_timeout  <= 1'b0;
    end else begin
      r_state <= w_next;
      // busy/valid are decoded from the next state so they are true flops.
      r_busy  <= (w_next != S_IDLE);
      r_valid <= (w_next == S_DONE);

      unique case (r_state)
        S_IDLE: begin
          if (bus.start) begin
            r_count <= 8'd0;
            r_ovf   <= 1'b0;
          end
        end
        S_ARMED: begin
          if (w_wait_hit) begin
            r_duration <= 8'd0;
            r_bcd      <= 12'd0;
            r_overflow <= 1'b0;
            r_timeout  <= 1'b1;
          end
        end
        S_WAIT_HIGH: begin
          if (w_wait_hit) begin
            r_duration <= 8'd0;
            r_bcd      <= 12'd0;
            r_overflow <= 1'b0;
            r_timeout  <= 1'b1;
          end else if (bus.psi) begin
            r_count <= 8'd1;
          end
        end
        S_COUNT: begin
          if (bus.psi) begin
            if (r_count == 8'd255) r_ovf   <= 1'b1;
            else                   r_count <= r_count + 8'd1;
          end else begin
            r_shift <= {12'd0, r_count};
            r_iter  <= 3'd0;
          end
        end
        S_CONVERT: begin
          r_shift <= w_dd;
          r_iter  <= r_iter + 3'd1;
          if (r_iter == c_LAST_ITER) begin
            r_duration <= r_count;
            r_bcd      <= w_dd[19:8];
            r_overflow <= r_ovf;
            r_timeout  <= 1'b0;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign bus.busy     = r_busy;
  assign bus.valid    = r_valid;
  assign bus.duration = r_duration;
  assign bus.bcd_2    = r_bcd[11:8];
  assign bus.bcd_1    = r_bcd[7:4];
  assign bus.bcd_0    = r_bcd[3:0];
  assign bus.overflow = r_overflow;
  assign bus.timeout  = r_timeout;

endmodule
`default_nettype wire

// File: doc/pulse_measure_ctrl.md
# pulse_measure_ctrl

Sequencer for the single-pulse duration measurement path. On a `start` request it arms and waits for a clean low-to-high transition of `psi`. It then counts the clock cycles for which `psi` stays high. On the falling edge it converts the count to three BCD digits with a serial shift-add-3 loop and presents the result under a valid/ack handshake for the seven-segment display stage.

## Interface
- `TIMEOUT_CYCLES`, default 1000: cycles spent waiting in ARMED+WAIT_HIGH before aborting. Range 1..65535. Used only when `PULSE_TIMEOUT_EN` is defined.
- `clk`  in  1: system clock; all state updates on the rising edge.
- `rst`  in  1: asynchronous, active-low reset (asserted when 0).
- `start`  in  1: measurement request; sampled only in IDLE.
- `psi`  in  1: measured pulse, synchronous to `clk`.
- `ack`  in  1: result consumed; sampled only in DONE.
- `busy`  out  1: high whenever state ≠ IDLE.
- `valid`  out  1: high exactly while state = DONE.
- `duration`  out  8: binary pulse length in cycles, saturating.
- `bcd_2`, `bcd_1`, `bcd_0`  out  4 each: hundreds, tens and units of `duration`.
- `overflow`  out  1: pulse length exceeded 255 cycles.
- `timeout`  out  1: measurement aborted with no pulse.

## Operation
- States: IDLE, ARMED, WAIT_HIGH, COUNT, CONVERT, DONE. Reset enters IDLE.
- IDLE: `start`=1 moves to ARMED and clears the internal counters and `overflow`/`timeout`.
- ARMED:
  - `psi`=0 moves to WAIT_HIGH.
  - `psi`=1 stays in ARMED, so a pulse already in progress at start is never measured.
- WAIT_HIGH: `psi`=1 moves to COUNT with count ← 1.
- COUNT:
  - `psi`=1: count ← count+1, saturating at 255. An attempted increment at 255 sets internal overflow.
  - `psi`=0: moves to CONVERT.
- CONVERT:
  - Eight iterations of double-dabble on a 20-bit shift register {12-bit BCD, 8-bit binary}, one per cycle.
  - Each cycle: add 3 to every BCD nibble ≥5, then shift left by 1.
  - After the 8th iteration: load `duration`, `bcd_*` and `overflow` from the internal values, and move to DONE.
- DONE:
  - `valid`=1.
  - `ack`=1 moves to IDLE. Otherwise stay in DONE with all outputs held.
- Results persist: `duration`, `bcd_*`, `overflow` and `timeout` change only on entry to DONE or on reset.
- `start` is ignored outside IDLE. `ack` is ignored outside DONE.
- No abort input. Asserting `rst` mid-operation returns to IDLE immediately and clears all outputs.

## Timing
- Reset values: `busy`=0, `valid`=0, `duration`=0, `bcd_2`=`bcd_1`=`bcd_0`=0, `overflow`=0, `timeout`=0.
- `start` sampled at edge S: `busy` is high after S.
- Pulse length: `duration` = N, where N is the number of consecutive rising edges at which `psi` was sampled 1 in WAIT_HIGH/COUNT.
- Result latency: let F be the edge at which COUNT first samples `psi`=0. CONVERT occupies edges F+1..F+8, and `valid` is high after edge F+8.
- Handshake: `ack` sampled high at edge A in DONE gives `valid`=`busy`=0 after A. The earliest new `start` is accepted at A+1.
- `ack` held high across DONE entry is honoured at the first edge in DONE, so `valid` lasts exactly 1 cycle.
- All outputs are registered; there is no combinational path from input to output.

## Configuration
- `PULSE_TIMEOUT_EN` defined:
  - A 16-bit wait counter runs in ARMED and WAIT_HIGH.
  - When it reaches `TIMEOUT_CYCLES`, the block moves straight to DONE with `timeout`=1, `duration`=0, all `bcd_*`=0 and `overflow`=0.
  - Leaving WAIT_HIGH for COUNT stops the counter; COUNT has no timeout.
- Undefined:
  - The wait counter is not built, and ARMED/WAIT_HIGH wait indefinitely.
  - `timeout` is tied to 0 and `TIMEOUT_CYCLES` is unused.

## Test plan
- Reset then idle: `rst`=0 for 2 cycles, release, no `start` → all outputs 0 and `busy`=0 for 20 cycles.
- Basic measurement: `start` pulse with `psi`=0, then `psi` high for 37 cycles → `valid` 8 cycles after the falling-edge sample, `duration`=37, `bcd_2..0`=0,3,7. Then `ack` → `valid`=0 next cycle.
- Pre-existing pulse: `psi` already high at `start`, stays high 10 cycles, low 5, then high 200 → `duration`=200, digits 2,0,0. The first pulse is ignored.
- Saturation: `psi` high for 300 cycles → `duration`=255, digits 2,5,5, `overflow`=1. The next 12-cycle measurement reports `overflow`=0.
- Timeout (macro on, `TIMEOUT_CYCLES`=50): `start` with `psi` held 0 → `valid` and `timeout`=1 with `duration`=0 at wait count 50. With the macro off, the same stimulus leaves `busy`=1 and `valid`=0 for 200 cycles.
- Reset mid-operation: `rst` asserted during COUNT and again during CONVERT → `busy`=0 and outputs cleared immediately. A subsequent 5-cycle pulse measures `duration`=5.
